// File: rtl/vco_quantizer.sv
// Multi-channel ring-oscillator VCO quantizer: synchronises each ring's phase taps,
// decodes them to a phase index, and sums phase advances over an oversampling window.
module vco_quantizer #(
  parameter int PHASE_WIDTH = 11,
  parameter int NUM_CH      = 2,
  parameter int OSR_WIDTH   = 10,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          mode,
  input  logic [OSR_WIDTH-1:0]          osr,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] p,
  output logic [NUM_CH*ACC_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH-1:0]             err,
  output logic                          ovf
);

  localparam int N     = PHASE_WIDTH;
  localparam int IDX_W = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                               state_q, state_d;
  logic [1:0]                           prime_q, prime_d;
  logic [NUM_CH*N-1:0]                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_CH-1:0][IDX_W-1:0]         idx_q, idx_d, idx_prev_q, idx_prev_d;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [OSR_WIDTH-1:0]                 cnt_q, cnt_d, osr_q, osr_d;
  logic                                 mode_q, mode_d;
  logic [NUM_CH*ACC_WIDTH-1:0]          out_data_q, out_data_d;
  logic                                 out_valid_q, out_valid_d;
  logic [NUM_CH-1:0]                    err_q, err_d;
  logic                                 ovf_q, ovf_d;

  logic [NUM_CH-1:0]                    illegal;
  logic [NUM_CH-1:0][IDX_W-1:0]         delta;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0]     acc_sum;
  logic [NUM_CH*ACC_WIDTH-1:0]          result;
  logic                                 close;

  // Thermometer-style decode: popcount gives position, tap 0 tells which half-cycle.
  always_comb begin
    sync1_d    = p;
    sync2_d    = sync1_q;
    idx_prev_d = idx_q;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [N-1:0]     code;
      logic [IDX_W-1:0] ones;
      logic             seen;
      code       = sync2_q[c*N +: N];
      ones       = '0;
      seen       = 1'b0;
      illegal[c] = 1'b0;
      for (int i = 0; i < N; i++) ones = ones + IDX_W'(code[i]);
      for (int i = 0; i < N - 1; i++) begin
        if (code[i] != code[i+1]) begin
          if (seen) illegal[c] = 1'b1;
          seen = 1'b1;
        end
      end
      if (code[0])           idx_d[c] = ones;
      else if (ones == '0)   idx_d[c] = '0;
      else                   idx_d[c] = IDX_W'(2 * N) - ones;

      if (idx_q[c] >= idx_prev_q[c]) delta[c] = idx_q[c] - idx_prev_q[c];
      else                           delta[c] = idx_q[c] + IDX_W'(2 * N) - idx_prev_q[c];

      begin
        logic [ACC_WIDTH:0] sum;
        sum = {1'b0, acc_q[c]} + (ACC_WIDTH + 1)'(delta[c]);
        acc_sum[c] = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
      end
      result[c*ACC_WIDTH +: ACC_WIDTH] = mode_q ? ACC_WIDTH'(idx_q[c]) : acc_sum[c];
    end
    err_d = err_q | illegal;
  end

  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    osr_d   = osr_q;
    mode_d  = mode_q;
    close   = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d   = '0;
        cnt_d   = '0;
        prime_d = '0;
        if (en) begin
          state_d = PRIME;
          osr_d   = (osr == '0) ? OSR_WIDTH'(1) : osr;
          mode_d  = mode;
        end
      end
      PRIME: begin
        if (!en) begin
          state_d = IDLE;
        end else if (prime_q == 2'd2) begin
          state_d = RUN;
          prime_d = '0;
        end else begin
          prime_d = prime_q + 2'd1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == osr_q - OSR_WIDTH'(1)) begin
          close = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + OSR_WIDTH'(1);
          acc_d = mode_q ? '0 : acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A consumer accepting in the same cycle frees the slot for the closing window.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (close) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = result;
        out_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prime_q     <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      idx_q       <= '0;
      idx_prev_q  <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      osr_q       <= OSR_WIDTH'(1);
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_q     <= prime_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      idx_q       <= idx_d;
      idx_prev_q  <= idx_prev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      osr_q       <= osr_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vco_quantizer.sv
// Directed bench for vco_quantizer: ch0 ring advances at a programmable rate,
// ch1 is driven with explicit codes; expected results are hand-computed constants.
module tb_vco_quantizer;

  localparam int N   = 11;
  localparam int NCH = 2;
  localparam int OW  = 10;
  localparam int AW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              mode;
  logic [OW-1:0]     osr;
  logic [NCH*N-1:0]  p;
  logic [NCH*AW-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [NCH-1:0]    err;
  logic              ovf;

  int                vectors     = 0;
  int                miscompares = 0;
  int                ph0         = 0;
  int                rate0       = 0;
  logic [N-1:0]      p1          = '0;

  vco_quantizer #(
    .PHASE_WIDTH(N), .NUM_CH(NCH), .OSR_WIDTH(OW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .osr(osr), .p(p),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Ring code for phase k: k ones from tap 0 up, then zeros filling in from tap 0.
  function automatic logic [N-1:0] phase_code(input int k);
    logic [N-1:0] ones;
    ones = '1;
    if (k <= N) return ones >> (N - k);
    else        return ones << (k - N);
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ph0 = (ph0 + rate0) % (2 * N);
      p   = {p1, phase_code(ph0)};
    end
  endtask

  task automatic setCh1(input logic [N-1:0] code);
    p1 = code;
    p  = {p1, p[N-1:0]};
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; osr = 10'd8; out_ready = 1'b1;
    rate0 = 1;
    p = {p1, phase_code(ph0)};
    applyStimulus(3);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_data",  64'(out_data),  64'd0);
    checkOutput("reset_err",   64'(err),       64'd0);
    checkOutput("reset_ovf",   64'(ovf),       64'd0);

    // steady advance, osr 8
    rst_n = 1'b1;
    applyStimulus(5);
    en = 1'b1;
    applyStimulus(11);
    checkOutput("steady_not_yet", 64'(out_valid), 64'd0);
    applyStimulus(1);
    checkOutput("steady_valid1", 64'(out_valid), 64'd1);
    checkOutput("steady_data1",  64'(out_data),  {32'd0, 16'd0, 16'd8});
    applyStimulus(1);
    checkOutput("steady_consumed", 64'(out_valid), 64'd0);
    applyStimulus(7);
    checkOutput("steady_valid2", 64'(out_valid), 64'd1);
    checkOutput("steady_data2",  64'(out_data),  {32'd0, 16'd0, 16'd8});

    // wrap: 3 states per clock through 21 -> 0, osr 4
    en = 1'b0;
    applyStimulus(1);
    rate0 = 3; osr = 10'd4;
    applyStimulus(6);
    en = 1'b1;
    applyStimulus(8);
    checkOutput("wrap_valid1", 64'(out_valid), 64'd1);
    checkOutput("wrap_data1",  64'(out_data),  {32'd0, 16'd0, 16'd12});
    applyStimulus(4);
    checkOutput("wrap_data2",  64'(out_data),  {32'd0, 16'd0, 16'd12});

    // one-cycle illegal code on ch1
    setCh1(11'b00000000110);
    applyStimulus(1);
    setCh1('0);
    applyStimulus(3);
    checkOutput("illegal_err", 64'(err), 64'b10);
    checkOutput("illegal_ch0", 64'(out_data[AW-1:0]), 64'd12);
    applyStimulus(4);
    checkOutput("illegal_ch0_next", 64'(out_data[AW-1:0]), 64'd12);
    en = 1'b0;
    applyStimulus(2);
    en = 1'b1;
    applyStimulus(2);
    checkOutput("err_sticky_en", 64'(err), 64'b10);
    rst_n = 1'b0; en = 1'b0;
    applyStimulus(1);
    checkOutput("err_cleared", 64'(err), 64'd0);
    checkOutput("reset2_valid", 64'(out_valid), 64'd0);

    // backpressure, osr 4
    rst_n = 1'b1; rate0 = 1; osr = 10'd4; mode = 1'b0; out_ready = 1'b0;
    applyStimulus(5);
    en = 1'b1;
    applyStimulus(8);
    checkOutput("bp_valid1", 64'(out_valid), 64'd1);
    checkOutput("bp_data1",  64'(out_data),  {32'd0, 16'd0, 16'd4});
    checkOutput("bp_ovf0",   64'(ovf),       64'd0);
    setCh1(phase_code(5));
    applyStimulus(3);
    checkOutput("bp_hold", 64'(out_data), {32'd0, 16'd0, 16'd4});
    applyStimulus(1);
    checkOutput("bp_ovf1",       64'(ovf),       64'd1);
    checkOutput("bp_hold_drop",  64'(out_data),  {32'd0, 16'd0, 16'd4});
    checkOutput("bp_valid_held", 64'(out_valid), 64'd1);
    applyStimulus(1);
    out_ready = 1'b1;
    applyStimulus(1);
    checkOutput("bp_delivered", 64'(out_valid), 64'd0);
    applyStimulus(2);
    checkOutput("bp_valid3", 64'(out_valid), 64'd1);
    checkOutput("bp_data3",  64'(out_data),  {32'd0, 16'd0, 16'd4});
    checkOutput("bp_ovf_sticky", 64'(ovf), 64'd1);

    // mode 1, osr 0, ch0 held at phase 15
    rst_n = 1'b0; en = 1'b0;
    applyStimulus(1);
    checkOutput("reset3_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1; rate0 = 0; ph0 = 15; setCh1('0);
    mode = 1'b1; osr = 10'd0; out_ready = 1'b1;
    applyStimulus(5);
    en = 1'b1;
    applyStimulus(4);
    checkOutput("m1_not_yet", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("m1_valid", 64'(out_valid), 64'd1);
      checkOutput("m1_data",  64'(out_data),  {32'd0, 16'd0, 16'd15});
    end
    checkOutput("m1_ovf", 64'(ovf), 64'd0);

    // reset mid-window with a held result
    en = 1'b0;
    applyStimulus(2);
    out_ready = 1'b0; mode = 1'b0; osr = 10'd8; rate0 = 1;
    applyStimulus(4);
    en = 1'b1;
    applyStimulus(12);
    checkOutput("mid_valid", 64'(out_valid), 64'd1);
    checkOutput("mid_data",  64'(out_data),  {32'd0, 16'd0, 16'd8});
    applyStimulus(5);
    rst_n = 1'b0; en = 1'b0;
    applyStimulus(1);
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_data",  64'(out_data),  64'd0);
    checkOutput("mid_rst_ovf",   64'(ovf),       64'd0);
    checkOutput("mid_rst_err",   64'(err),       64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    applyStimulus(2);
    en = 1'b1;
    applyStimulus(11);
    checkOutput("fresh_not_yet", 64'(out_valid), 64'd0);
    applyStimulus(1);
    checkOutput("fresh_valid", 64'(out_valid), 64'd1);
    checkOutput("fresh_data",  64'(out_data),  {32'd0, 16'd0, 16'd8});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
